remote_pos_to_ring_ctrl: RTL and testbench

// - Unpacks 512-bit position beats from the remote-input FIFO into single position packets for the ring node.
// - Sits between the first-word-fall-through remote FIFO and the position-input ring node; one packet is offered at a time and retired on ring ack.
// - Pops the FIFO once per beat and flags that the remote node has finished sending for this iteration.

---
 rtl/remote_pos_to_ring_ctrl.sv | 119 +++++++++++
 tb/tb_remote_pos_to_ring_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_pos_to_ring_ctrl.sv
// rtl/remote_pos_to_ring_ctrl.sv - unpacks 512-bit remote FIFO beats into single ring position packets
// Optional feature macro: REMOTE_POS_ZERO_LIFETIME_SKIP_EN (skip lifetime-0 data slots).
module remote_pos_to_ring_ctrl #(
   parameter int AXIS_TDATA_WIDTH        = 512,
   parameter int SLOT_WIDTH              = 128,
   parameter int OFFSET_PKT_STRUCT_WIDTH = 80,
   parameter int GLOBAL_CELL_ID_WIDTH    = 3,
   parameter int NB_CELL_COUNT_WIDTH     = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [AXIS_TDATA_WIDTH-1:0]          i_remote_tdata,
   input  logic                                 i_remote_tvalid,
   input  logic                                 i_remote_ack_from_ring,
   output logic [OFFSET_PKT_STRUCT_WIDTH-1:0]   o_remote_offset_pkt,
   output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]    o_remote_gcid,
   output logic                                 o_remote_valid,
   output logic [NB_CELL_COUNT_WIDTH-1:0]       o_remote_lifetime,
   output logic                                 o_last_transfer_from_remote,
   output logic                                 o_remote_input_buf_ack
);

   localparam int NUM_SLOTS = AXIS_TDATA_WIDTH / SLOT_WIDTH;
   localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int OFF_W     = OFFSET_PKT_STRUCT_WIDTH;
   localparam int GCID_W    = 3 * GLOBAL_CELL_ID_WIDTH;
   localparam int LIFE_W    = NB_CELL_COUNT_WIDTH;
   localparam int USED_W    = OFF_W + GCID_W + LIFE_W;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                      state_q;
   logic [AXIS_TDATA_WIDTH-1:0] beat_q;
   logic [IDX_W-1:0]            idx_q;
   logic                        last_q;

   logic [SLOT_WIDTH-1:0]       slots [NUM_SLOTS];
   logic [SLOT_WIDTH-1:0]       cur_slot;
   logic [OFF_W-1:0]            cur_off;
   logic [GCID_W-1:0]           cur_gcid;
   logic [LIFE_W-1:0]           cur_life;
   logic                        cur_marker;
   logic                        cur_skip;
   logic                        sending;
   logic                        data_valid;
   logic                        advance;
   logic                        at_last_slot;
   logic                        pop;
   logic                        unused_slot_bits;

   always_comb begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
         slots[k] = beat_q[k*SLOT_WIDTH +: SLOT_WIDTH];
      end
   end

   assign cur_slot   = slots[idx_q];
   assign cur_off    = cur_slot[OFF_W-1:0];
   assign cur_gcid   = cur_slot[OFF_W +: GCID_W];
   assign cur_life   = cur_slot[OFF_W+GCID_W +: LIFE_W];
   assign cur_marker = &cur_off;
   assign unused_slot_bits = ^cur_slot[SLOT_WIDTH-1:USED_W];

`ifdef REMOTE_POS_ZERO_LIFETIME_SKIP_EN
   // A packet with no hops left is dropped here but is not an end-of-stream marker.
   assign cur_skip = cur_marker || (cur_life == '0);
`else
   assign cur_skip = cur_marker;
`endif

   assign sending      = (state_q == SEND);
   assign data_valid   = sending && !cur_skip;
   assign advance      = sending && (cur_skip || i_remote_ack_from_ring);
   assign at_last_slot = (idx_q == IDX_W'(NUM_SLOTS - 1));
   // The FIFO is first-word-fall-through, so rd_en in the same cycle as tvalid retires the beat.
   assign pop          = (state_q == IDLE) && i_remote_tvalid && !rst;

   assign o_remote_input_buf_ack      = pop;
   assign o_remote_valid              = data_valid;
   assign o_remote_offset_pkt         = data_valid ? cur_off  : '0;
   assign o_remote_gcid               = data_valid ? cur_gcid : '0;
   assign o_remote_lifetime           = data_valid ? cur_life : '0;
   assign o_last_transfer_from_remote = last_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  beat_q  <= i_remote_tdata;
                  idx_q   <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (cur_marker) begin
                  last_q <= 1'b1;
               end
               if (advance) begin
                  idx_q <= idx_q + 1'b1;
                  if (at_last_slot) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_remote_pos_to_ring_ctrl.sv
// tb/tb_remote_pos_to_ring_ctrl.sv - self-checking bench for remote_pos_to_ring_ctrl
module tb_remote_pos_to_ring_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic [511:0]  i_remote_tdata;
   logic          i_remote_tvalid;
   logic          i_remote_ack_from_ring;
   logic [79:0]   o_remote_offset_pkt;
   logic [8:0]    o_remote_gcid;
   logic          o_remote_valid;
   logic [3:0]    o_remote_lifetime;
   logic          o_last_transfer_from_remote;
   logic          o_remote_input_buf_ack;

   always #5 clk = ~clk;

   remote_pos_to_ring_ctrl dut (
      .clk                         (clk),
      .rst                         (rst),
      .i_remote_tdata              (i_remote_tdata),
      .i_remote_tvalid             (i_remote_tvalid),
      .i_remote_ack_from_ring      (i_remote_ack_from_ring),
      .o_remote_offset_pkt         (o_remote_offset_pkt),
      .o_remote_gcid               (o_remote_gcid),
      .o_remote_valid              (o_remote_valid),
      .o_remote_lifetime           (o_remote_lifetime),
      .o_last_transfer_from_remote (o_last_transfer_from_remote),
      .o_remote_input_buf_ack      (o_remote_input_buf_ack)
   );

   typedef struct packed {
      logic [79:0] off;
      logic [8:0]  gcid;
      logic [3:0]  life;
   } pkt_t;

   typedef struct packed {
      logic [3:0][79:0] off;
      logic [3:0][8:0]  gcid;
      logic [3:0][3:0]  life;
   } vec_t;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           cyc     = 0;
   int           n_pops, n_valid, last_pop, prev_pop, first_valid;
   logic [511:0] fifo_q [$];
   pkt_t         sb_q [$];
   vec_t         vecs [4];

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [511:0] mk_beat(vec_t v);
      logic [511:0] b;
      for (int k = 0; k < 4; k++) begin
         b[k*128 +: 128] = {35'h5DEADBEEF, v.life[k], v.gcid[k], v.off[k]};
      end
      return b;
   endfunction

   task automatic drive_fifo();
      i_remote_tvalid = (fifo_q.size() > 0);
      i_remote_tdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
   endtask

   // Queues the beat in the FIFO model and the packets it should produce in the scoreboard.
   task automatic push_beat(input vec_t v, output int npkts, output logic has_marker);
      logic skip;
      fifo_q.push_back(mk_beat(v));
      npkts = 0;
      has_marker = 1'b0;
      for (int k = 0; k < 4; k++) begin
         skip = (v.off[k] == {80{1'b1}});
         if (skip) has_marker = 1'b1;
`ifdef REMOTE_POS_ZERO_LIFETIME_SKIP_EN
         if (v.life[k] == 4'd0) skip = 1'b1;
`endif
         if (!skip) begin
            sb_q.push_back({v.off[k], v.gcid[k], v.life[k]});
            npkts++;
         end
      end
      drive_fifo();
   endtask

   task automatic tick();
      logic pop_seen;
      pkt_t got;
      pkt_t exp;
      @(negedge clk);
      pop_seen = o_remote_input_buf_ack;
      if (o_remote_valid) begin
         n_valid++;
         if (first_valid < 0) first_valid = cyc;
      end
      if (pop_seen) begin
         n_pops++;
         prev_pop = last_pop;
         last_pop = cyc;
         check("pop_while_valid", {127'd0, o_remote_valid}, 128'd0);
         check("pop_underflow", {127'd0, i_remote_tvalid}, 128'd1);
      end
      if (o_remote_valid && i_remote_ack_from_ring) begin
         got = {o_remote_offset_pkt, o_remote_gcid, o_remote_lifetime};
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pkt: got %0h, expected none", got);
         end else begin
            exp = sb_q.pop_front();
            check("pkt", {35'd0, got}, {35'd0, exp});
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   task automatic clear_stats();
      n_pops = 0; n_valid = 0; last_pop = -1; prev_pop = -1; first_valid = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_remote_ack_from_ring = 1'b0;
      fifo_q.delete();
      sb_q.delete();
      drive_fifo();
      repeat (3) tick();
      rst = 1'b0;
      clear_stats();
   endtask

   initial begin
      int           np;
      logic         mk;
      logic [511:0] mbeat;

      vecs[0].off  = {80'd4, 80'd3, 80'd2, 80'd1};
      vecs[0].gcid = {9'd0, 9'd0, 9'd0, 9'd0};
      vecs[0].life = {4'd3, 4'd3, 4'd3, 4'd3};
      vecs[1].off  = {80'd8, {80{1'b1}}, 80'd6, 80'd5};
      vecs[1].gcid = {9'd1, 9'd2, 9'd3, 9'd4};
      vecs[1].life = {4'd7, 4'd7, 4'd7, 4'd7};
      vecs[2].off  = {80'h1234_5678_9ABC_DEF0_1111, 80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFE, 80'h8000_0000_0000_0000_0001};
      vecs[2].gcid = {9'h1FF, 9'h0AA, 9'h155, 9'h000};
      vecs[2].life = {4'd0, 4'd15, 4'd1, 4'd8};
      vecs[3].off  = {80'hC0FFEE, 80'hBEEF, 80'hCAFE, {80{1'b1}}};
      vecs[3].gcid = {9'd7, 9'd6, 9'd5, 9'd4};
      vecs[3].life = {4'd2, 4'd2, 4'd0, 4'd9};

      // Reset held with a beat waiting: nothing may pop or be offered.
      rst = 1'b1;
      i_remote_ack_from_ring = 1'b1;
      clear_stats();
      fifo_q.push_back(mk_beat(vecs[0]));
      drive_fifo();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_buf_ack", {127'd0, o_remote_input_buf_ack}, 128'd0);
         check("rst_valid", {127'd0, o_remote_valid}, 128'd0);
         check("rst_last", {127'd0, o_last_transfer_from_remote}, 128'd0);
         check("rst_fields", {35'd0, o_remote_offset_pkt, o_remote_gcid, o_remote_lifetime}, 128'd0);
      end
      check("rst_pops", n_pops, 0);

      // All-marker beat: one pop, nothing offered, sticky last flag.
      do_reset();
      i_remote_ack_from_ring = 1'b1;
      mbeat = {4{32'h00015244, {96{1'b1}}}};
      fifo_q.push_back(mbeat);
      drive_fifo();
      repeat (6) tick();
      check("marker_last", {127'd0, o_last_transfer_from_remote}, 128'd1);
      repeat (10) tick();
      check("marker_last_sticky", {127'd0, o_last_transfer_from_remote}, 128'd1);
      check("marker_pops", n_pops, 1);
      check("marker_valid_cycles", n_valid, 0);

      // Table vectors with ack held high.
      for (int v = 0; v < 4; v++) begin
         do_reset();
         i_remote_ack_from_ring = 1'b1;
         push_beat(vecs[v], np, mk);
         repeat (12) tick();
         check("vec_pops", n_pops, 1);
         check("vec_valid_cycles", n_valid, np);
         check("vec_sb_drained", sb_q.size(), 0);
         check("vec_last", {127'd0, o_last_transfer_from_remote}, {127'd0, mk});
         if (vecs[v].off[0] != {80{1'b1}} && np > 0)
            check("vec_first_latency", first_valid - last_pop, 1);
      end

      // Ack withheld: slot 0 must hold until acked, then slot 1 follows.
      do_reset();
      push_beat(vecs[0], np, mk);
      tick();
      check("hold_pop", n_pops, 1);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {127'd0, o_remote_valid}, 128'd1);
         check("hold_off", {48'd0, o_remote_offset_pkt}, 128'd1);
         tick();
      end
      i_remote_ack_from_ring = 1'b1;
      tick();
      i_remote_ack_from_ring = 1'b0;
      check("hold_next_valid", {127'd0, o_remote_valid}, 128'd1);
      check("hold_next_off", {48'd0, o_remote_offset_pkt}, 128'd2);
      tick();
      check("hold_still_off", {48'd0, o_remote_offset_pkt}, 128'd2);
      i_remote_ack_from_ring = 1'b1;
      repeat (6) tick();
      check("hold_sb_drained", sb_q.size(), 0);
      check("hold_total_pops", n_pops, 1);

      // Back-to-back beats: pops are one SEND pass plus one bubble apart.
      do_reset();
      i_remote_ack_from_ring = 1'b1;
      push_beat(vecs[0], np, mk);
      push_beat(vecs[1], np, mk);
      repeat (16) tick();
      check("b2b_pops", n_pops, 2);
      check("b2b_spacing", last_pop - prev_pop, 5);
      check("b2b_sb_drained", sb_q.size(), 0);
      check("b2b_last", {127'd0, o_last_transfer_from_remote}, 128'd1);

      // Reset in the middle of SEND discards the latched beat.
      do_reset();
      i_remote_ack_from_ring = 1'b0;
      push_beat(vecs[0], np, mk);
      repeat (2) tick();
      do_reset();
      i_remote_ack_from_ring = 1'b1;
      repeat (4) tick();
      check("rst_send_valid", n_valid, 0);
      check("rst_send_pops", n_pops, 0);
      check("rst_send_outs", {35'd0, o_remote_offset_pkt, o_remote_gcid, o_remote_lifetime}, 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
